// File: rtl/riscv_test_pkg.sv
// Shared encodings for the riscv-tests tohost result monitor.
package riscv_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_PASS    = 2'b01,
    RES_FAIL    = 2'b10,
    RES_TIMEOUT = 2'b11
  } res_code_e;

  localparam logic [31:0] TOHOST_PASS_VAL     = 32'h0000_0001;
  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
  localparam logic [3:0]  BE_FULL_WORD        = 4'b1111;

endpackage

// File: rtl/test_cycle_counter.sv
// Saturating RUN-cycle counter with a terminal-count compare (TC of 0 never fires).
module test_cycle_counter #(
  parameter logic [31:0] TC = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] count_o,
  output logic        tc_c_o
);

  logic [31:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 32'd0;
    end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;
  // Fires during the last allowed cycle, so the terminal state lands exactly after TC cycles.
  assign tc_c_o  = (TC != 32'd0) && (count_q == (TC - 32'd1));

endmodule

// File: rtl/test_status_monitor.sv
// Watches core writes to tohost and reports pass/fail/timeout over a valid/ready handshake.
module test_status_monitor
  import riscv_test_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        run_en,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic [2:0]  state_o,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] fail_testnum,
  output logic [31:0] cycle_count,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_code
);

  state_e      state_q;
  logic        done_q, pass_q, fail_q, timeout_q, res_valid_q;
  logic [30:0] fail_testnum_q;
  res_code_e   res_code_q;
  logic        tc_c;
  logic        hit_c;

  test_cycle_counter #(
    .TC (TIMEOUT_CYCLES)
  ) u_cycle_counter (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .en_i    (state_q == ST_RUN),
    .count_o (cycle_count),
    .tc_c_o  (tc_c)
  );

  assign hit_c = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_be == BE_FULL_WORD);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= ST_IDLE;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      res_valid_q    <= 1'b0;
      res_code_q     <= RES_NONE;
      fail_testnum_q <= 31'd0;
    end else begin
      if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (run_en) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Hit outranks timeout; even tohost values are syscalls and are ignored.
          if (hit_c && (dmem_wdata == TOHOST_PASS_VAL)) begin
            state_q     <= ST_PASS;
            done_q      <= 1'b1;
            pass_q      <= 1'b1;
            res_valid_q <= 1'b1;
            res_code_q  <= RES_PASS;
          end else if (hit_c && dmem_wdata[0]) begin
            state_q        <= ST_FAIL;
            done_q         <= 1'b1;
            fail_q         <= 1'b1;
            res_valid_q    <= 1'b1;
            res_code_q     <= RES_FAIL;
            fail_testnum_q <= dmem_wdata[31:1];
          end else if (tc_c) begin
            state_q     <= ST_TIMEOUT;
            done_q      <= 1'b1;
            timeout_q   <= 1'b1;
            res_valid_q <= 1'b1;
            res_code_q  <= RES_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o      = state_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign fail_testnum = fail_testnum_q;
  assign res_valid    = res_valid_q;
  assign res_code     = res_code_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed plus randomized bench for test_status_monitor against a per-cycle reference model.
module tb_test_status_monitor;
  import riscv_test_pkg::*;

  localparam logic [31:0] TO   = 32'd100;
  localparam logic [31:0] ADDR = 32'h0000_1000;
  localparam logic [3:0]  FULL = 4'b1111;

  logic        sys_clk = 1'b0;
  logic        sys_rst, run_en, dmem_we, res_ready;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [2:0]  state_o;
  logic        done, pass, fail, timeout, res_valid;
  logic [30:0] fail_testnum;
  logic [31:0] cycle_count;
  logic [1:0]  res_code;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 run, 2 pass, 3 fail, 4 timeout
  int          m_phase = 0;
  longint      m_runs  = 0;
  logic        m_valid = 1'b0;
  logic [30:0] m_num   = 31'd0;

  test_status_monitor #(
    .TOHOST_ADDR    (ADDR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .run_en       (run_en),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .state_o      (state_o),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .fail_testnum (fail_testnum),
    .cycle_count  (cycle_count),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_code     (res_code)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_state();
    case (m_phase)
      1:       return ST_RUN;
      2:       return ST_PASS;
      3:       return ST_FAIL;
      4:       return ST_TIMEOUT;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] exp_code();
    case (m_phase)
      2:       return RES_PASS;
      3:       return RES_FAIL;
      4:       return RES_TIMEOUT;
      default: return RES_NONE;
    endcase
  endfunction

  task automatic model_step();
    logic   hit;
    longint prior;
    hit = dmem_we && (dmem_addr == ADDR) && (dmem_be == FULL);
    if (sys_rst) begin
      m_phase = 0; m_runs = 0; m_valid = 1'b0; m_num = 31'd0;
    end else begin
      case (m_phase)
        0: if (run_en) m_phase = 1;
        1: begin
          prior  = m_runs;
          m_runs = m_runs + 1;
          if (hit && dmem_wdata == 32'h1) begin
            m_phase = 2; m_valid = 1'b1;
          end else if (hit && dmem_wdata[0]) begin
            m_phase = 3; m_valid = 1'b1; m_num = dmem_wdata[31:1];
          end else if (prior == longint'(TO) - 1) begin
            m_phase = 4; m_valid = 1'b1;
          end
        end
        default: if (m_valid && res_ready) m_valid = 1'b0;
      endcase
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_cnt;
    exp_cnt = (m_runs > longint'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : 32'(m_runs);
    check("state",        32'(state_o),      32'(exp_state()));
    check("done",         32'(done),         32'(m_phase >= 2));
    check("pass",         32'(pass),         32'(m_phase == 2));
    check("fail",         32'(fail),         32'(m_phase == 3));
    check("timeout",      32'(timeout),      32'(m_phase == 4));
    check("fail_testnum", 32'(fail_testnum), 32'(m_num));
    check("cycle_count",  cycle_count,       exp_cnt);
    check("res_valid",    32'(res_valid),    32'(m_valid));
    check("res_code",     32'(res_code),     32'(exp_code()));
  endtask

  task automatic tick();
    model_step();
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d; dmem_be = be;
  endtask

  // Random bus traffic that is never an odd-valued full-word tohost write.
  task automatic nohit();
    dmem_we    = 1'($urandom);
    dmem_wdata = $urandom;
    dmem_be    = 4'($urandom);
    case ($urandom_range(0, 2))
      0:       dmem_addr = ADDR;
      1:       dmem_addr = ADDR + 32'd4;
      default: dmem_addr = $urandom;
    endcase
    if (dmem_we && dmem_addr == ADDR && dmem_be == FULL) dmem_wdata[0] = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; run_en = 1'b0; nohit(); tick();
    sys_rst = 1'b0;
  endtask

  task automatic start_run();
    run_en = 1'b1; nohit(); tick();
    run_en = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; run_en = 1'b0; res_ready = 1'b0;
    dmem_we = 1'b0; dmem_addr = 32'd0; dmem_wdata = 32'd0; dmem_be = 4'd0;
    #1;
    tick(); tick();
    sys_rst = 1'b0;

    // Pass on the 40th RUN cycle, then a stalled reporter
    start_run();
    repeat (39) begin nohit(); tick(); end
    wr(ADDR, 32'h1, FULL); tick();
    check("pass_count_frozen", cycle_count, 32'd40);
    check("pass_state", 32'(state_o), 32'(ST_PASS));
    repeat (10) begin
      run_en = 1'($urandom);
      wr(ADDR, $urandom_range(0, 1) == 0 ? 32'h7 : 32'h1, FULL);
      tick();
    end
    res_ready = 1'b1; nohit(); tick();
    check("handshake_drop", 32'(res_valid), 32'd0);
    repeat (5) begin res_ready = 1'($urandom); nohit(); tick(); end
    res_ready = 1'b0;

    // Fail with testnum 3, later pass write ignored, reset while valid with a hit
    do_reset();
    start_run();
    repeat (5) begin nohit(); tick(); end
    wr(ADDR, 32'h7, FULL); tick();
    check("fail_testnum3", 32'(fail_testnum), 32'd3);
    wr(ADDR, 32'h1, FULL); tick();
    check("fail_sticky", 32'(state_o), 32'(ST_FAIL));
    sys_rst = 1'b1; res_ready = 1'b1; wr(ADDR, 32'h1, FULL); tick();
    check("rst_in_fail", 32'(state_o), 32'(ST_IDLE));
    sys_rst = 1'b0; res_ready = 1'b0;
    wr(ADDR, 32'h1, FULL); tick();
    check("idle_ignores_hit", 32'(state_o), 32'(ST_IDLE));

    // Timeout after exactly 100 RUN cycles
    start_run();
    repeat (99) begin nohit(); tick(); end
    check("pre_timeout", 32'(state_o), 32'(ST_RUN));
    nohit(); tick();
    check("timeout_state", 32'(state_o), 32'(ST_TIMEOUT));
    check("timeout_count", cycle_count, 32'd100);
    repeat (3) begin res_ready = 1'($urandom); nohit(); tick(); end

    // Hit on the timeout cycle wins
    do_reset();
    start_run();
    repeat (99) begin nohit(); tick(); end
    wr(ADDR, 32'h1, FULL); tick();
    check("hit_beats_timeout", 32'(state_o), 32'(ST_PASS));

    // Syscall, partial-byte and wrong-address writes are all ignored
    do_reset();
    start_run();
    wr(ADDR, 32'h2, FULL);            tick();
    wr(ADDR, 32'h1, 4'b0001);         tick();
    wr(ADDR + 32'd4, 32'h1, FULL);    tick();
    check("ignored_writes", 32'(state_o), 32'(ST_RUN));

    // Reset mid-RUN with a simultaneous hit
    sys_rst = 1'b1; wr(ADDR, 32'h1, FULL); tick();
    check("rst_mid_run", cycle_count, 32'd0);
    sys_rst = 1'b0;

    // Randomized episodes
    repeat (6) begin
      do_reset();
      repeat (150) begin
        run_en    = ($urandom_range(0, 3) != 0);
        sys_rst   = ($urandom_range(0, 99) == 0);
        res_ready = 1'($urandom);
        if ($urandom_range(0, 39) == 0)
          wr(ADDR, ($urandom_range(0, 2) == 0) ? 32'h1 : $urandom, FULL);
        else
          nohit();
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
